// File: rtl/approx_popcount_accum.sv
// Streaming popcount accumulator: per-nibble exact or approximate counts, summed over
// BEATS-word frames, with a registered threshold compare and valid/ready on both sides.
module approx_popcount_accum #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned BEATS  = 4,
  parameter int unsigned THRESH = 20,
  localparam int unsigned ACC_W = $clog2(WIDTH * BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_fire,
  output logic             out_mode
);

  localparam int unsigned GROUPS = WIDTH / 4;
  localparam int unsigned WC_W   = $clog2(WIDTH + 1);
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] S_ACCUM = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic             mode_q, mode_d;
  logic             s1_vld_q, s1_vld_d;
  logic [WC_W-1:0]  s1_cnt_q, s1_cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             fire_q, fire_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic             hs_in;
  logic             cur_mode;
  logic [WC_W-1:0]  word_cnt;

  // Count of one nibble; the approximate cell saturates at 3 and never sets bit 2.
  function automatic logic [2:0] grp_cnt(input logic [3:0] n, input logic approx);
    if (approx) begin
      return {1'b0, (n[0] & n[1]) | (n[2] & n[3]), (n[0] ^ n[1]) | n[2] | n[3]};
    end
    return 3'(n[0]) + 3'(n[1]) + 3'(n[2]) + 3'(n[3]);
  endfunction

  assign hs_in = in_valid & in_ready_q;

  // The first beat uses the live mode input; later beats use the latched frame mode.
  always_comb begin
    cur_mode = (beat_q == '0) ? mode : mode_q;
    word_cnt = '0;
    for (int unsigned g = 0; g < GROUPS; g++) begin
      word_cnt = word_cnt + WC_W'(grp_cnt(in_data[4*g +: 4], cur_mode));
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    mode_d   = mode_q;
    acc_d    = acc_q;
    s1_vld_d = hs_in;
    s1_cnt_d = hs_in ? word_cnt : '0;

    if (s1_vld_q) begin
      acc_d = acc_q + ACC_W'(s1_cnt_q);
    end

    case (state_q)
      S_ACCUM: begin
        if (hs_in) begin
          if (beat_q == '0) begin
            mode_d = mode;
          end
          if (beat_q == CNT_W'(BEATS - 1)) begin
            beat_d  = '0;
            state_d = S_DRAIN;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      S_DRAIN: state_d = S_HOLD;
      S_HOLD: begin
        if (out_ready) begin
          state_d  = S_ACCUM;
          acc_d    = '0;
          s1_vld_d = 1'b0;
          s1_cnt_d = '0;
        end
      end
      default: state_d = S_ACCUM;
    endcase

    fire_d      = (32'(acc_d) >= THRESH);
    in_ready_d  = (state_d == S_ACCUM);
    out_valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_ACCUM;
      beat_q      <= '0;
      mode_q      <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_cnt_q    <= '0;
      acc_q       <= '0;
      fire_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      mode_q      <= mode_d;
      s1_vld_q    <= s1_vld_d;
      s1_cnt_q    <= s1_cnt_d;
      acc_q       <= acc_d;
      fire_q      <= fire_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign out_fire  = fire_q;
  assign out_mode  = mode_q;

endmodule

// File: tb/tb_approx_popcount_accum.sv
// Bench for approx_popcount_accum: frame-level reference model checked every cycle,
// directed frames with literal expectations, then a randomized stream.
module tb_approx_popcount_accum;

  localparam int unsigned W = 16;
  localparam int unsigned B = 4;
  localparam int unsigned T = 20;
  localparam int unsigned AW = $clog2(W * B + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mode;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic          out_fire;
  logic          out_mode;

  approx_popcount_accum #(.WIDTH(W), .BEATS(B), .THRESH(T)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_fire(out_fire), .out_mode(out_mode)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference count of one word straight from the nibble rules.
  function automatic int word_count(input logic [W-1:0] w, input logic approx);
    int c = 0;
    for (int g = 0; g < int'(W / 4); g++) begin
      logic [3:0] n;
      n = w[4*g +: 4];
      if (!approx) c += $countones(n);
      else c += 2 * int'((n[0] & n[1]) | (n[2] & n[3])) + int'((n[0] ^ n[1]) | n[2] | n[3]);
    end
    return c;
  endfunction

  // Frame model: beats collected, result pending from last handshake to transfer.
  int   m_idx = 0;
  int   m_sum = 0;
  logic m_mode = 1'b0;
  bit   pending = 0;
  int   p_sum, exp_cyc;
  logic p_fire, p_mode;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_sum", int'(out_sum), 0);
      check("rst_out_fire", int'(out_fire), 0);
      check("rst_out_mode", int'(out_mode), 0);
      m_idx   = 0;
      m_sum   = 0;
      pending = 0;
    end else begin
      check("in_ready", int'(in_ready), int'(!pending));
      check("out_valid", int'(out_valid), int'(pending && cyc >= exp_cyc));
      if (out_valid && pending) begin
        check("model_sum", int'(out_sum), p_sum);
        check("model_fire", int'(out_fire), int'(p_fire));
        check("model_mode", int'(out_mode), int'(p_mode));
      end
      if (in_valid && in_ready) begin
        if (m_idx == 0) m_mode = mode;
        m_sum += word_count(in_data, m_mode);
        m_idx++;
        if (m_idx == int'(B)) begin
          pending = 1;
          p_sum   = m_sum;
          p_fire  = (m_sum >= int'(T));
          p_mode  = m_mode;
          exp_cyc = cyc + 2;
          m_idx   = 0;
          m_sum   = 0;
        end
      end
      if (out_valid && out_ready) pending = 0;
    end
  end

  int last_hs, seen_cyc;

  task automatic send(input logic m, input logic [W-1:0] d);
    mode     = m;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        last_hs = cyc;
        @(posedge clk);
        #1;
        return;
      end
    end
    check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_result(input string nm, input int s, input int f, input int m);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        check({nm, "_sum"}, int'(out_sum), s);
        check({nm, "_fire"}, int'(out_fire), f);
        check({nm, "_mode"}, int'(out_mode), m);
        seen_cyc = cyc;
        @(posedge clk);
        #1;
        return;
      end
    end
    check({nm, "_timeout"}, 0, 1);
  endtask

  task automatic frame(input logic m, input logic [W-1:0] d);
    for (int b = 0; b < int'(B); b++) send(m, d);
    in_valid = 1'b0;
  endtask

  bit rand_done = 0;

  initial begin
    logic [W-1:0] gap_words [4];
    gap_words[0] = 16'h0001;
    gap_words[1] = 16'h0003;
    gap_words[2] = 16'h0007;
    gap_words[3] = 16'h000F;

    rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    frame(1'b0, 16'hFFFF);
    expect_result("exact_ffff", 64, 1, 0);
    check("latency", seen_cyc - last_hs, 2);

    frame(1'b1, 16'hFFFF);
    expect_result("approx_ffff", 48, 1, 1);
    frame(1'b1, 16'h6666);
    expect_result("approx_6666", 16, 0, 1);
    frame(1'b0, 16'h6666);
    expect_result("exact_6666", 32, 1, 0);

    // Mode wiggles after the first beat must not affect the frame.
    send(1'b0, 16'hFFFF); send(1'b1, 16'hFFFF); send(1'b0, 16'hFFFF); send(1'b1, 16'hFFFF);
    in_valid = 1'b0;
    expect_result("toggle", 64, 1, 0);
    frame(1'b1, 16'hFFFF);
    expect_result("toggle_next", 48, 1, 1);

    // Backpressure in HOLD with a new frame already offered.
    out_ready = 1'b0;
    frame(1'b0, 16'h00FF);
    in_valid = 1'b1; in_data = 16'hFFFF; mode = 1'b0;
    for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_sum", int'(out_sum), 32);
      check("bp_fire", int'(out_fire), 1);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("xfer_in_ready", int'(in_ready), 0);
    @(negedge clk);
    check("post_xfer_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    frame(1'b0, 16'hFFFF);
    expect_result("after_bp", 64, 1, 0);

    // Gapped input stream, exact then approximate.
    for (int a = 0; a < 2; a++) begin
      for (int b = 0; b < 4; b++) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        send(logic'(a), gap_words[b]);
      end
      in_valid = 1'b0;
      if (a == 0) expect_result("gap_exact", 10, 0, 0);
      else        expect_result("gap_approx", 9, 0, 1);
    end

    // Reset mid-frame.
    send(1'b0, 16'hFFFF); send(1'b0, 16'hFFFF);
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_sum", int'(out_sum), 0);
    check("midrst_fire", int'(out_fire), 0);
    check("midrst_mode", int'(out_mode), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    frame(1'b0, 16'h0000);
    expect_result("after_rst", 0, 0, 0);

    // Randomized stream with random gaps and backpressure.
    fork
      begin
        for (int f = 0; f < 30; f++) begin
          for (int b = 0; b < int'(B); b++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send(logic'($urandom_range(0, 1)), W'($urandom));
          end
          in_valid = 1'b0;
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = logic'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 100 && pending; i++) @(negedge clk);
    check("final_drain", int'(pending), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
